// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, instruction-cache FSM state and frame record.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Widest tag the cache can need (NSETS = 2 leaves 29 tag bits above the
  // index). Narrower configurations store their tag zero-extended.
  localparam int unsigned TAG_MAX_W = 29;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    word_t                data;
  } icache_frame_t;

endpackage

// File: rtl/icache_stats.sv
// Hit/miss event counters for the instruction cache; both wrap modulo 2^32.
module icache_stats
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  hit_inc,
  input  logic  miss_inc,
  output word_t hit_count,
  output word_t miss_count
);

  word_t hit_q, hit_d;
  word_t miss_q, miss_d;

  // Next counter values: bump on the corresponding event, otherwise hold.
  always_comb begin
    hit_d  = hit_q;
    miss_d = miss_q;
    if (hit_inc) begin
      hit_d = hit_q + 32'd1;
    end else begin
      hit_d = hit_q;
    end
    if (miss_inc) begin
      miss_d = miss_q + 32'd1;
    end else begin
      miss_d = miss_q;
    end
  end

  // Counter registers, cleared by the asynchronous reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_q  <= 32'd0;
      miss_q <= 32'd0;
    end else begin
      hit_q  <= hit_d;
      miss_q <= miss_d;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with a zero-latency hit
// path and a two-state (IDLE/FILL) refill FSM. Optional statistics counters
// are built when the macro ICACHE_STATS_EN is defined.
module icache
  import cpu_types_pkg::*;
#(
  parameter int unsigned NSETS = 16
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  imemREN,
  input  word_t imemaddr,
  output logic  ihit,
  output word_t imemload,
  output logic  iREN,
  output word_t iaddr,
  input  logic  iwait,
  input  word_t iload
`ifdef ICACHE_STATS_EN
  ,
  output word_t hit_count,
  output word_t miss_count
`endif
);

  localparam int unsigned IDX_W = $clog2(NSETS);

  icache_state_t        state_q, state_d;
  logic [29:0]          lat_q, lat_d;     // latched word address {tag,index}
  icache_frame_t        frames_q [NSETS];
  icache_frame_t        frames_d [NSETS];

  logic [IDX_W-1:0]     idx_s;
  logic [TAG_MAX_W-1:0] tag_s;
  logic [IDX_W-1:0]     fill_idx_s;
  logic [TAG_MAX_W-1:0] fill_tag_s;
  icache_frame_t        rd_frame_s;
  logic                 hit_s;
  logic                 miss_s;

  assign idx_s      = imemaddr[IDX_W+1:2];
  assign tag_s      = TAG_MAX_W'(imemaddr[31:IDX_W+2]);
  assign fill_idx_s = lat_q[IDX_W-1:0];
  assign fill_tag_s = TAG_MAX_W'(lat_q[29:IDX_W]);
  assign rd_frame_s = frames_q[idx_s];

  // Next-state logic: hit detection, miss capture and frame refill.
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    frames_d = frames_q;
    hit_s    = 1'b0;
    miss_s   = 1'b0;
    case (state_q)
      IDLE: begin
        hit_s = imemREN & rd_frame_s.valid & (rd_frame_s.tag == tag_s);
        if (imemREN && !hit_s) begin
          miss_s  = 1'b1;
          lat_d   = imemaddr[31:2];
          state_d = FILL;
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        // The fill runs to completion whatever the datapath does meanwhile.
        if (!iwait) begin
          frames_d[fill_idx_s] = '{valid: 1'b1, tag: fill_tag_s, data: iload};
          state_d              = IDLE;
        end else begin
          state_d = FILL;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode: data is forced to zero whenever there is no hit.
  always_comb begin
    ihit     = hit_s;
    imemload = 32'h0000_0000;
    iREN     = (state_q == FILL);
    iaddr    = {lat_q, 2'b00};
    if (hit_s) begin
      imemload = rd_frame_s.data;
    end else begin
      imemload = 32'h0000_0000;
    end
  end

  // State, latched address and frame storage; reset invalidates all frames.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      lat_q   <= 30'd0;
      for (int i = 0; i < int'(NSETS); i++) begin
        frames_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      frames_q <= frames_d;
    end
  end

`ifdef ICACHE_STATS_EN
  icache_stats u_stats (
    .CLK        (CLK),
    .nRST       (nRST),
    .hit_inc    (hit_s),
    .miss_inc   (miss_s),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );
`endif

endmodule

// File: tb/tb_icache.sv
// Directed, table-driven bench for icache (NSETS = 16).
module tb_icache;
  import cpu_types_pkg::*;

  logic  CLK;
  logic  nRST;
  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;
  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;
`ifdef ICACHE_STATS_EN
  word_t hit_count;
  word_t miss_count;
`endif

  icache #(.NSETS(16)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .ihit       (ihit),
    .imemload   (imemload),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iwait      (iwait),
    .iload      (iload)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic  ren;
    word_t addr;
    logic  iw;
    word_t load;
    logic  e_hit;
    word_t e_data;
    logic  e_ren;
    word_t e_iaddr;
  } vec_t;

  vec_t v[$];
  int   n_cmp;
  int   n_bad;

  function automatic vec_t mk(logic ren, word_t addr, logic iw, word_t load,
                              logic e_hit, word_t e_data, logic e_ren, word_t e_iaddr);
    vec_t r;
    r.ren = ren; r.addr = addr; r.iw = iw; r.load = load;
    r.e_hit = e_hit; r.e_data = e_data; r.e_ren = e_ren; r.e_iaddr = e_iaddr;
    return r;
  endfunction

  task automatic chk(input string name, input word_t act, input word_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic e_hit, input word_t e_data,
                          input logic e_ren, input word_t e_iaddr);
    chk({tag, "_ihit"},     {31'd0, ihit}, {31'd0, e_hit});
    chk({tag, "_imemload"}, imemload,      e_data);
    chk({tag, "_iREN"},     {31'd0, iREN}, {31'd0, e_ren});
    chk({tag, "_iaddr"},    iaddr,         e_iaddr);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    nRST     = 1'b0;
    imemREN  = 1'b1;
    imemaddr = 32'h0;
    iwait    = 1'b1;
    iload    = 32'h0;

    //        ren   addr          iw    load          hit   data          iREN  iaddr
    v.push_back(mk(1'b0, 32'h0000_0000, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0000_0000));
    v.push_back(mk(1'b1, 32'h0000_0000, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0000_0000));
    v.push_back(mk(1'b1, 32'h0000_0000, 1'b1, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_0000));
    v.push_back(mk(1'b1, 32'h0000_0000, 1'b1, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_0000));
    v.push_back(mk(1'b1, 32'h0000_0000, 1'b0, 32'h2401_0001, 1'b0, 32'h0,         1'b1, 32'h0000_0000));
    v.push_back(mk(1'b1, 32'h0000_0000, 1'b1, 32'h0,         1'b1, 32'h2401_0001, 1'b0, 32'h0000_0000));
    v.push_back(mk(1'b1, 32'h0000_0004, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0000_0000));
    v.push_back(mk(1'b1, 32'h0000_0004, 1'b0, 32'h1111_1111, 1'b0, 32'h0,         1'b1, 32'h0000_0004));
    v.push_back(mk(1'b1, 32'h0000_0006, 1'b1, 32'h0,         1'b1, 32'h1111_1111, 1'b0, 32'h0000_0004));
    v.push_back(mk(1'b1, 32'h0000_0000, 1'b1, 32'h0,         1'b1, 32'h2401_0001, 1'b0, 32'h0000_0004));
    v.push_back(mk(1'b1, 32'h0000_0040, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0000_0004));
    v.push_back(mk(1'b1, 32'h0000_0000, 1'b0, 32'h2222_2222, 1'b0, 32'h0,         1'b1, 32'h0000_0040));
    v.push_back(mk(1'b1, 32'h0000_0040, 1'b1, 32'h0,         1'b1, 32'h2222_2222, 1'b0, 32'h0000_0040));
    v.push_back(mk(1'b1, 32'h0000_0000, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0000_0040));
    v.push_back(mk(1'b0, 32'h0000_0040, 1'b0, 32'h2401_0001, 1'b0, 32'h0,         1'b1, 32'h0000_0000));
    v.push_back(mk(1'b0, 32'h0000_0000, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0000_0000));
    v.push_back(mk(1'b1, 32'h0000_0004, 1'b1, 32'h0,         1'b1, 32'h1111_1111, 1'b0, 32'h0000_0000));
    v.push_back(mk(1'b1, 32'h0000_0100, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0000_0000));
    v.push_back(mk(1'b1, 32'h0000_0200, 1'b1, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_0100));
    v.push_back(mk(1'b1, 32'h0000_0200, 1'b0, 32'h3333_3333, 1'b0, 32'h0,         1'b1, 32'h0000_0100));
    v.push_back(mk(1'b1, 32'h0000_0100, 1'b1, 32'h0,         1'b1, 32'h3333_3333, 1'b0, 32'h0000_0100));
    v.push_back(mk(1'b1, 32'h0000_0200, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0000_0100));
    v.push_back(mk(1'b1, 32'h0000_0200, 1'b0, 32'h4444_4444, 1'b0, 32'h0,         1'b1, 32'h0000_0200));
    v.push_back(mk(1'b1, 32'h0000_0200, 1'b1, 32'h0,         1'b1, 32'h4444_4444, 1'b0, 32'h0000_0200));
    v.push_back(mk(1'b1, 32'h0000_0100, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0000_0200));
    v.push_back(mk(1'b1, 32'h0000_0100, 1'b0, 32'h3333_3333, 1'b0, 32'h0,         1'b1, 32'h0000_0100));
    v.push_back(mk(1'b1, 32'h0000_0100, 1'b1, 32'h0,         1'b1, 32'h3333_3333, 1'b0, 32'h0000_0100));

    // Outputs while reset is held, with a fetch pending.
    #2;
    chk_outs("in_reset", 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    step();
    nRST = 1'b1;

    for (int i = 0; i < v.size(); i++) begin
      imemREN  = v[i].ren;
      imemaddr = v[i].addr;
      iwait    = v[i].iw;
      iload    = v[i].load;
      @(negedge CLK);
      chk_outs($sformatf("v%0d", i), v[i].e_hit, v[i].e_data, v[i].e_ren, v[i].e_iaddr);
      step();
    end

    // Reset asserted in the middle of a fill of 0x8.
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0008;
    iwait    = 1'b1;
    iload    = 32'h0;
    @(negedge CLK);
    chk_outs("rst_miss", 1'b0, 32'h0, 1'b0, 32'h0000_0100);
    step();
    chk_outs("rst_fill", 1'b0, 32'h0, 1'b1, 32'h0000_0008);
    nRST = 1'b0;
    #1;
    chk_outs("rst_drop", 1'b0, 32'h0, 1'b0, 32'h0);
    iwait = 1'b0;
    iload = 32'h5555_5555;
    step();
    chk_outs("rst_hold", 1'b0, 32'h0, 1'b0, 32'h0);
    nRST  = 1'b1;
    iwait = 1'b1;
    imemaddr = 32'h0000_0008;
    #1;
    chk_outs("rst_no_write8", 1'b0, 32'h0, 1'b0, 32'h0);
    imemaddr = 32'h0000_0000;
    #1;
    chk_outs("rst_miss0", 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    chk_outs("rst_refill0", 1'b0, 32'h0, 1'b1, 32'h0);

`ifdef ICACHE_STATS_EN
    // One miss followed by three hits.
    nRST = 1'b0;
    #1;
    chk("stats_rst_hit",  hit_count,  32'd0);
    chk("stats_rst_miss", miss_count, 32'd0);
    step();
    nRST     = 1'b1;
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0010;
    iwait    = 1'b0;
    iload    = 32'h6666_6666;
    step();
    step();
    step();
    step();
    step();
    imemREN = 1'b0;
    step();
    chk("stats_hit",  hit_count,  32'd3);
    chk("stats_miss", miss_count, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter NSETS, default 16, number of direct-mapped one-word frames (power of two, 2..256).
REQ-002 SHALL have CLK  input  1  rising-edge clock for all state.
REQ-003 SHALL have nRST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have imemREN  input  1  datapath fetch request.
REQ-005 SHALL have imemaddr  input  32  fetch byte address, bits [1:0] ignored.
REQ-006 SHALL have ihit  output  1  imemload valid for imemaddr this cycle.
REQ-007 SHALL have imemload  output  32  instruction word.
REQ-008 SHALL have iREN  output  1  memory-side read request.
REQ-009 SHALL have iaddr  output  32  memory-side word address, bits [1:0] = 0.
REQ-010 SHALL have iwait  input  1  memory busy; iload is valid in any cycle with iREN=1 and iwait=0.
REQ-011 SHALL have iload  input  32  memory read data.

Function
REQ-012 SHALL split the address as: index = imemaddr[2+log2(NSETS)-1:2]; tag = remaining upper bits.
REQ-013 SHALL store valid, tag and data per frame.
REQ-014 SHALL implement FSM states IDLE and FILL.
REQ-015 IDLE: ihit SHALL be combinational = imemREN & valid[index] & (tag match), with imemload = frame data in the same cycle (zero-latency hit).
REQ-016 IDLE with imemREN=1 and a miss: ihit=0; SHALL latch {tag,index} at the clock edge and enter FILL.
REQ-017 IDLE with imemREN=0: SHALL hold ihit=0, iREN=0, and leave the FSM and frames unchanged.
REQ-018 FILL: SHALL assert iREN=1 and iaddr = latched address; ihit SHALL be 0 regardless of imemaddr.
REQ-019 FILL with iwait=0: SHALL write iload, the latched tag and valid=1 into the latched frame at the clock edge, then return to IDLE.
REQ-020 Miss latency SHALL be (memory wait cycles + 1) cycles of FILL, plus one IDLE cycle in which the hit is presented.
REQ-021 Any imemaddr or imemREN change during FILL (branch redirect, pause) SHALL NOT abort the fill; the latched line SHALL still be written.
REQ-022 A fill that evicts a valid frame SHALL overwrite it unconditionally (no write-back; instruction memory is read-only).
REQ-023 imemload SHALL be 0 whenever ihit=0.

Reset
REQ-024 nRST low SHALL clear every valid bit, force state IDLE and clear the latched address, asynchronously.
REQ-025 During and after reset, until the next miss: ihit=0, iREN=0, iaddr=0, imemload=0.
REQ-026 Reset asserted mid-FILL SHALL abandon the fill with no frame written; iREN SHALL drop within the same cycle.

Configuration
REQ-027 Macro ICACHE_STATS_EN, when defined, SHALL add outputs hit_count and miss_count (32 bits each, reset 0, wrapping modulo 2^32), incremented once per IDLE cycle with a hit and once per IDLE->FILL transition respectively.
REQ-028 Without ICACHE_STATS_EN, those ports and counters SHALL be absent, with all other behaviour identical.

Structure
REQ-029 word_t SHALL come from cpu_types_pkg; icache_state_t (IDLE, FILL) and the frame struct (valid, tag, data) SHALL be added to cpu_types_pkg.
REQ-030 The statistics counters SHALL live in one sub-module, icache_stats, instantiated only under ICACHE_STATS_EN; the frame array and FSM stay in icache.

Verification
REQ-031 Cold miss: reset, then imemREN=1 with imemaddr=0x00000000 and iwait=1 for 2 cycles then 0 with iload=0x24010001 -> iREN high for 3 cycles with iaddr=0, then ihit=1 and imemload=0x24010001 on the following cycle.
REQ-032 Hit: refetch 0x00000000 -> ihit=1 in the same cycle, with iREN=0.
REQ-033 Conflict (NSETS=16): fill 0x00000040 after 0x00000000 -> 0x00000000 misses again; 0x00000004 (index 1) is unaffected.
REQ-034 Redirect: change imemaddr from 0x100 to 0x200 during FILL of 0x100 -> frame 0 holds the tag of 0x100; 0x200 then misses and fills.
REQ-035 Reset mid-FILL: nRST low while iREN=1 -> iREN=0 immediately; after release, 0x0 misses.
REQ-036 Under ICACHE_STATS_EN, 1 miss + 3 hits -> miss_count=1 and hit_count=3.
